// File: rtl/apb_mem_slave.sv
// APB3 completer backed by a single-region word memory, with programmable wait
// states, error responses for out-of-region or misaligned accesses, and a backdoor preload port.
module apb_mem_slave #(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] REGION_START = 32'h0001_F000,
    parameter logic [31:0] REGION_SIZE  = 32'h0000_1000,
    parameter int          WAIT_CYCLES  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    output logic [DATA_WIDTH-1:0] prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    input  logic                  bd_we_i,
    input  logic [ADDR_WIDTH-1:0] bd_addr_i,
    input  logic [DATA_WIDTH-1:0] bd_wdata_i
);

    localparam int DEPTH = int'(REGION_SIZE >> 2);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   REGION_LO = (ADDR_WIDTH+1)'(REGION_START);
    localparam logic [ADDR_WIDTH:0]   REGION_HI = REGION_LO + (ADDR_WIDTH+1)'(REGION_SIZE);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(REGION_START);
    localparam logic [3:0]            WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Region bounds are compared one bit wider so REGION_START+REGION_SIZE cannot wrap.
    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH:0] a_ext;
        a_ext = {1'b0, addr};
        return (a_ext < REGION_LO) || (a_ext >= REGION_HI) || (addr[1:0] != 2'b00);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    state_t                state_r, state_nxt_s;
    logic [3:0]            cnt_r, cnt_nxt_s;
    logic [ADDR_WIDTH-1:0] lat_addr_r;
    logic [DATA_WIDTH-1:0] lat_wdata_r;
    logic                  lat_write_r, lat_err_r;
    logic                  pready_r, pready_nxt_s;
    logic                  pslverr_r, pslverr_nxt_s;
    logic [DATA_WIDTH-1:0] prdata_r, prdata_nxt_s;
    logic                  latch_s, finish_s, commit_s;
    logic                  sel_err_s, sel_write_s;
    logic [IDX_W-1:0]      sel_idx_s;
    logic                  bd_ok_s;

    // Zero-wait transfers complete straight from IDLE, so they decode the live bus.
    always_comb begin
        if (state_r == ST_IDLE) begin
            sel_err_s   = addr_err(paddr_i);
            sel_write_s = pwrite_i;
            sel_idx_s   = word_idx(paddr_i);
        end else begin
            sel_err_s   = lat_err_r;
            sel_write_s = lat_write_r;
            sel_idx_s   = word_idx(lat_addr_r);
        end
    end

    // Next-state and next-output logic of the transfer FSM.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        pready_nxt_s  = 1'b0;
        pslverr_nxt_s = 1'b0;
        prdata_nxt_s  = prdata_r;
        latch_s       = 1'b0;
        finish_s      = 1'b0;
        commit_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (psel_i && !penable_i) begin
                    latch_s = 1'b1;
                    if (WAIT_LOAD == 4'd0) begin
                        state_nxt_s = ST_DONE;
                        finish_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = WAIT_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!psel_i) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end else if (penable_i) begin
                    if (cnt_r <= 4'd1) begin
                        state_nxt_s = ST_DONE;
                        cnt_nxt_s   = 4'd0;
                        finish_s    = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r - 4'd1;
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                commit_s    = lat_write_r & ~lat_err_r;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
        if (finish_s) begin
            pready_nxt_s  = 1'b1;
            pslverr_nxt_s = sel_err_s;
            if (sel_err_s) begin
                prdata_nxt_s = '0;
            end else if (!sel_write_s) begin
                prdata_nxt_s = mem_r[sel_idx_s];
            end else begin
                prdata_nxt_s = prdata_r;
            end
        end else begin
            pready_nxt_s  = 1'b0;
            pslverr_nxt_s = 1'b0;
        end
    end

    // FSM, counter, registered outputs and setup-phase latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            pready_r    <= 1'b0;
            pslverr_r   <= 1'b0;
            prdata_r    <= '0;
            lat_addr_r  <= '0;
            lat_wdata_r <= '0;
            lat_write_r <= 1'b0;
            lat_err_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            pready_r  <= pready_nxt_s;
            pslverr_r <= pslverr_nxt_s;
            prdata_r  <= prdata_nxt_s;
            if (latch_s) begin
                lat_addr_r  <= paddr_i;
                lat_wdata_r <= pwdata_i;
                lat_write_r <= pwrite_i;
                lat_err_r   <= addr_err(paddr_i);
            end
        end
    end

    assign bd_ok_s = bd_we_i & ~addr_err(bd_addr_i);

    // Memory array: the APB write is issued last so it wins a same-word collision.
    always_ff @(posedge clk) begin
        if (bd_ok_s) begin
            mem_r[word_idx(bd_addr_i)] <= bd_wdata_i;
        end
        if (commit_s && !rst) begin
            mem_r[word_idx(lat_addr_r)] <= lat_wdata_r;
        end
    end

    assign prdata_o  = prdata_r;
    assign pready_o  = pready_r;
    assign pslverr_o = pslverr_r;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances (0, 3 and 2 wait states) checked
// against an array-based memory model with directed tables, corner sequences and random traffic.
module tb_apb_mem_slave;

    localparam logic [31:0] START = 32'h0001_F000;
    localparam logic [31:0] SIZE  = 32'h0000_1000;
    localparam int          ND    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        psel[ND], penable[ND], pwrite[ND], pready[ND], pslverr[ND], bd_we[ND];
    logic [31:0] paddr[ND], pwdata[ND], prdata[ND], bd_addr[ND], bd_wdata[ND];

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl[ND][1024];
    logic [31:0] last_prd[ND];

    typedef struct {
        int          d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
    } vec_t;
    vec_t tbl[$];

    genvar g;
    generate
        for (g = 0; g < ND; g++) begin : g_dut
            apb_mem_slave #(
                .ADDR_WIDTH(32), .DATA_WIDTH(32),
                .REGION_START(START), .REGION_SIZE(SIZE),
                .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
            ) u_dut (
                .clk(clk), .rst(rst),
                .psel_i(psel[g]), .penable_i(penable[g]), .pwrite_i(pwrite[g]),
                .paddr_i(paddr[g]), .pwdata_i(pwdata[g]),
                .prdata_o(prdata[g]), .pready_o(pready[g]), .pslverr_o(pslverr[g]),
                .bd_we_i(bd_we[g]), .bd_addr_i(bd_addr[g]), .bd_wdata_i(bd_wdata[g])
            );
        end
    endgenerate

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
    endfunction

    function automatic bit m_err(input logic [31:0] a);
        longint unsigned la;
        la = longint'(a);
        return (la < longint'(START)) || (la >= longint'(START) + longint'(SIZE)) || (a[1:0] != 2'b00);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - START) / 4) & 1023;
    endfunction

    function automatic logic [31:0] gen_addr();
        int r;
        r = int'($urandom_range(0, 9));
        case (r)
            0:       return $urandom;
            1:       return START + 32'($urandom_range(0, 4095));
            2:       return ($urandom_range(0, 1) == 0) ? START - 32'd4 : START + SIZE;
            default: return START + 32'd4 * 32'($urandom_range(0, 1023));
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One APB transfer; expectations are supplied by the caller, the model is updated afterwards.
    task automatic do_xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input bit exp_err, input string name);
        int waits;
        @(negedge clk);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wdata;
        @(negedge clk);
        penable[d] = 1'b1; paddr[d] = ~addr; pwdata[d] = ~wdata;
        waits = 0;
        while (pready[d] !== 1'b1 && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        check({name, " latency"}, 32'(waits), 32'(wait_of(d)));
        if (pready[d] === 1'b1) begin
            check({name, " pslverr"}, 32'(pslverr[d]), 32'(exp_err));
            check({name, " prdata"}, prdata[d], exp_rd);
        end
        if (m_err(addr)) begin
            last_prd[d] = 32'h0;
        end else if (wr) begin
            mdl[d][m_idx(addr)] = wdata;
        end else begin
            last_prd[d] = mdl[d][m_idx(addr)];
        end
    endtask

    task automatic model_xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input string name);
        bit          e;
        logic [31:0] rd;
        e  = m_err(addr);
        rd = e ? 32'h0 : (wr ? last_prd[d] : mdl[d][m_idx(addr)]);
        do_xfer(d, wr, addr, wdata, rd, e, name);
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        psel[d] = 1'b0; penable[d] = 1'b0;
        check($sformatf("d%0d pready_drop", d), 32'(pready[d]), 32'h0);
        check($sformatf("d%0d pslverr_drop", d), 32'(pslverr[d]), 32'h0);
    endtask

    task automatic bd_write(input int d, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bd_we[d] = 1'b1; bd_addr[d] = addr; bd_wdata[d] = data;
        @(negedge clk);
        bd_we[d] = 1'b0;
        if (!m_err(addr)) mdl[d][m_idx(addr)] = data;
    endtask

    task automatic add(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input bit err);
        tbl.push_back('{d: d, wr: wr, addr: addr, wdata: wdata, rdata: rdata, err: err});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = 32'h0; pwdata[d] = 32'h0;
            bd_we[d] = 1'b0; bd_addr[d] = 32'h0; bd_wdata[d] = 32'h0; last_prd[d] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("d%0d reset pready", d), 32'(pready[d]), 32'h0);
            check($sformatf("d%0d reset pslverr", d), 32'(pslverr[d]), 32'h0);
            check($sformatf("d%0d reset prdata", d), prdata[d], 32'h0);
        end
        rst = 1'b0;

        // Preload every word of every instance through the backdoor.
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                bd_we[d] = 1'b1; bd_addr[d] = START + 32'(4 * i); bd_wdata[d] = $urandom;
                mdl[d][i] = bd_wdata[d];
            end
        end
        @(negedge clk);
        for (int d = 0; d < ND; d++) bd_we[d] = 1'b0;
        bd_write(0, START, 32'h0BAD_F00D);
        bd_write(1, START, 32'h1234_5678);

        add(0, 1'b1, 32'h0001_F010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        add(0, 1'b0, 32'h0001_F010, 32'h0,         32'hDEAD_BEEF, 1'b0);
        add(0, 1'b1, 32'h0002_F000, 32'h5555_5555, 32'h0, 1'b1);
        add(0, 1'b0, 32'h0001_F002, 32'h0,         32'h0, 1'b1);
        add(0, 1'b0, 32'h0001_F000, 32'h0,         32'h0BAD_F00D, 1'b0);
        add(0, 1'b1, 32'h0001_FFFC, 32'h5A5A_5A5A, 32'h0, 1'b0);
        add(0, 1'b0, 32'h0001_FFFC, 32'h0,         32'h5A5A_5A5A, 1'b0);
        add(0, 1'b0, 32'h0002_0000, 32'h0,         32'h0, 1'b1);
        add(0, 1'b0, 32'h0001_EFFC, 32'h0,         32'h0, 1'b1);
        add(1, 1'b0, 32'h0001_F000, 32'h0,         32'h1234_5678, 1'b0);
        add(1, 1'b1, 32'h0001_F004, 32'hCAFE_F00D, 32'h0, 1'b0);
        add(1, 1'b0, 32'h0001_F004, 32'h0,         32'hCAFE_F00D, 1'b0);
        add(1, 1'b1, 32'h0001_F001, 32'hFFFF_FFFF, 32'h0, 1'b1);
        add(1, 1'b0, 32'h0001_F000, 32'h0,         32'h1234_5678, 1'b0);
        add(2, 1'b1, 32'h0001_F008, 32'h0123_4567, 32'h0, 1'b0);
        add(2, 1'b0, 32'h0001_F008, 32'h0,         32'h0123_4567, 1'b0);
        foreach (tbl[i]) begin
            do_xfer(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                    (tbl[i].wr && !tbl[i].err) ? last_prd[tbl[i].d] : tbl[i].rdata,
                    tbl[i].err, $sformatf("vec%0d", i));
            idle(tbl[i].d);
        end

        // Back-to-back bursts with psel held high between transfers.
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 16; k++)
                do_xfer(d, 1'b1, START + 32'(4 * k), 32'(k + 1), last_prd[d], 1'b0, $sformatf("d%0d b2b_wr%0d", d, k));
            idle(d);
            for (int k = 0; k < 16; k++)
                do_xfer(d, 1'b0, START + 32'(4 * k), 32'h0, 32'(k + 1), 1'b0, $sformatf("d%0d b2b_rd%0d", d, k));
            idle(d);
        end

        // APB write and backdoor write hit the same word on the same edge.
        do_xfer(0, 1'b1, 32'h0001_F040, 32'h1, last_prd[0], 1'b0, "collide_wr");
        bd_we[0] = 1'b1; bd_addr[0] = 32'h0001_F040; bd_wdata[0] = 32'h2;
        idle(0);
        bd_we[0] = 1'b0;
        do_xfer(0, 1'b0, 32'h0001_F040, 32'h0, 32'h1, 1'b0, "collide_rd");
        idle(0);

        // Abort: psel dropped while the write is still waiting.
        bd_write(2, 32'h0001_F020, 32'hAAAA_5555);
        @(negedge clk);
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'h0001_F020; pwdata[2] = 32'h1212_1212;
        @(negedge clk);
        penable[2] = 1'b1;
        check("abort pready_a1", 32'(pready[2]), 32'h0);
        @(negedge clk);
        psel[2] = 1'b0; penable[2] = 1'b0;
        check("abort pready_a2", 32'(pready[2]), 32'h0);
        repeat (2) begin
            @(negedge clk);
            check("abort pready_after", 32'(pready[2]), 32'h0);
        end
        do_xfer(2, 1'b0, 32'h0001_F020, 32'h0, 32'hAAAA_5555, 1'b0, "abort_rd");
        idle(2);

        // Reset asserted while a write waits; pending write must be lost.
        @(negedge clk);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h0001_F030; pwdata[1] = 32'h7777_7777;
        @(negedge clk);
        penable[1] = 1'b1;
        check("rst_wait pready_a1", 32'(pready[1]), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("d%0d midrst pready", d), 32'(pready[d]), 32'h0);
            check($sformatf("d%0d midrst pslverr", d), 32'(pslverr[d]), 32'h0);
            check($sformatf("d%0d midrst prdata", d), prdata[d], 32'h0);
            last_prd[d] = 32'h0;
        end
        @(negedge clk);
        check("rst_noset pready", 32'(pready[1]), 32'h0);
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge clk);
        check("rst_idle pready", 32'(pready[1]), 32'h0);
        model_xfer(1, 1'b0, 32'h0001_F030, 32'h0, "rst_rd");
        idle(1);

        // Random traffic against the model, with idle gaps and occasional backdoor writes.
        for (int d = 0; d < ND; d++) begin
            for (int n = 0; n < 150; n++) begin
                model_xfer(d, 1'($urandom_range(0, 1)), gen_addr(), $urandom, $sformatf("d%0d rnd%0d", d, n));
                if ($urandom_range(0, 2) == 0) begin
                    idle(d);
                    if ($urandom_range(0, 3) == 0) bd_write(d, gen_addr(), $urandom);
                end
            end
            idle(d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
